ahb_slave_arbiter_gen: RTL and testbench
========================================

AHB_SLAVE_ARBITER_GEN -- requirements
Module: ahb_slave_arbiter_gen

Interface
REQ-001 SHALL have parameter MASTER_NUM, default 4: number of requesting masters, range 2..16.
REQ-002 SHALL have parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-003 SHALL have parameter MAX_HOLD, default 16: beat limit for undefined-length INCR when the timeout feature is compiled in; range 2..255.
REQ-004 SHALL derive local parameter MIDX_W = $clog2(MASTER_NUM).
REQ-005 SHALL have port hclk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port hreset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port hreq, input, MASTER_NUM bits: per-master bus request.
REQ-008 SHALL have port hburst, input, hburst_type from AHB_package: burst type of the granted master's transfer.
REQ-009 SHALL have port hwait, input, 1 bit: slave wait; a beat completes only when it is 0.
REQ-010 SHALL have port hgrant, output, MASTER_NUM bits: one-hot grant, qualified by ~hwait.
REQ-011 SHALL have port hsel, output, 1 bit: slave selected, i.e. any master owns the bus.
REQ-012 SHALL have port hmaster, output, MIDX_W bits: index of the current owner.
REQ-013 SHALL have port hlast, output, 1 bit: the current beat is the last beat of the owner's transaction.

Function
REQ-014 SHALL implement FSM IDLE/BUSY, with a registered one-hot grant_q.
REQ-015 IDLE: if |hreq, the winner's bit is loaded into grant_q at the next edge and the FSM moves to BUSY; otherwise the FSM stays in IDLE with grant_q = 0.
REQ-016 On the first BUSY cycle, SHALL latch hburst into burst_q; the beat limit derives from burst_q only: SINGLE 0, *4 3, *8 7, *16 15, INCR undefined.
REQ-017 SHALL use a 5-bit beat counter, cleared on entry to BUSY and incremented on every BUSY cycle with hwait = 0.
REQ-018 hlast SHALL be 1 in BUSY when: count == limit (fixed burst); or the owner's hreq = 0 (INCR); or the timeout of REQ-030 fires.
REQ-019 The last beat completes when hlast = 1 and hwait = 0; then:
- if any other hreq bit is 1, grant_q loads the new winner at the next edge (back-to-back, no idle cycle) and the FSM stays in BUSY with the counter cleared;
- otherwise grant_q becomes 0 and the FSM returns to IDLE.
REQ-020 The owner's own request SHALL be excluded from the rearbitration at REQ-019 unless no other master requests; in that case the owner re-wins.
REQ-021 hwait = 1 on the last beat SHALL hold grant_q, the count and the FSM state unchanged.
REQ-022 Fixed mode: the lowest-index asserted hreq wins.
REQ-023 Round robin mode: a pointer rr_ptr is set to (owner+1) mod MASTER_NUM at each last-beat completion, and the search starts at rr_ptr, wrapping from MASTER_NUM-1 to 0.
REQ-024 A request change during BUSY SHALL NOT preempt the owner; transactions are never split.
REQ-025 hgrant SHALL equal grant_q & {MASTER_NUM{~hwait}}, hsel SHALL equal |grant_q, and hmaster SHALL equal the encoded grant_q, held at its last value when grant_q = 0.
REQ-026 grant_q SHALL always be one-hot or zero.

Reset
REQ-027 Reset SHALL be asynchronous on hreset_n = 0; release SHALL be synchronous to hclk.
REQ-028 Reset values: FSM IDLE, grant_q 0, hgrant 0, hsel 0, hmaster 0, hlast 0, count 0, rr_ptr 0, burst_q SINGLE, hold counter 0.
REQ-029 Reset mid-burst SHALL abandon the transaction; the first grant after release follows IDLE rules with rr_ptr = 0.

Configuration
REQ-030 Macro ARB_INCR_TIMEOUT_EN:
- defined: an 8-bit hold counter counts completed beats of an INCR transaction; when it reaches MAX_HOLD-1 while another hreq bit is 1, hlast is forced to 1, so the owner is released at beat MAX_HOLD.
- undefined: the hold counter and its logic are absent, and an INCR transaction lasts until the owner's hreq drops.

Verification
REQ-031 Scenario: MASTER_NUM = 4, fixed mode, hreq = 4'b0110 in IDLE -> grant_q = 4'b0010 one cycle later, hsel = 1, hmaster = 1.
REQ-032 Scenario: round robin, all four masters request continuously with SINGLE bursts and hwait = 0 -> grant sequence 0,1,2,3,0 on consecutive cycles, hlast = 1 every cycle.
REQ-033 Scenario: master 2 issues INCR8 with hwait = 1 on beats 3 and 8 -> hlast = 1 only on the 8th completed beat; grant is held 10 cycles; hgrant[2] = 0 during the wait cycles.
REQ-034 Scenario: INCR with master 0, hreq[0] dropped after 5 beats, master 3 requesting -> hlast on the 5th beat, then grant_q = 4'b1000 with no idle cycle.
REQ-035 Scenario: ARB_INCR_TIMEOUT_EN defined, MAX_HOLD = 4, master 1 holds INCR, master 2 requests -> hlast on beat 4, then hmaster = 2.
REQ-036 Scenario: hreset_n pulsed low during beat 2 of a WRAP4 burst -> all outputs 0 immediately; after release, hreq = 4'b1000 -> grant_q = 4'b1000.

Source files
------------

// File: rtl/ahb_slave_arbiter_gen.sv
// -----------------------------------------------------------------------------
// ahb_slave_arbiter_gen
//   Arbitrates access to one AHB slave between MASTER_NUM requesting masters.
//   The bus is granted for a whole transaction (fixed-length burst, or an
//   undefined-length INCR that lasts while the owner keeps requesting) and is
//   handed over back-to-back on the last beat. Fixed priority or round robin.
//
//   Optional feature macro: ARB_INCR_TIMEOUT_EN
//     When defined, an INCR owner is forced off the bus after MAX_HOLD beats
//     if another master is waiting.
//
// Ports
//   hclk      in   clock, rising edge
//   hreset_n  in   asynchronous active-low reset
//   hreq      in   [MASTER_NUM]  per-master bus request
//   hburst    in   hburst_type   burst type of the granted master's transfer
//   hwait     in   slave wait; a beat completes only when low
//   hgrant    out  [MASTER_NUM]  one-hot grant, masked while hwait is high
//   hsel      out  some master owns the bus
//   hmaster   out  [MIDX_W]      index of the current (or last) owner
//   hlast     out  current beat is the owner's last beat
// -----------------------------------------------------------------------------
package AHB_package;
  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_type;
endpackage

module ahb_slave_arbiter_gen
  import AHB_package::*;
#(
  parameter int MASTER_NUM = 4,
  parameter int ARB_MODE   = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                          hclk,
  input  logic                          hreset_n,
  input  logic [MASTER_NUM-1:0]         hreq,
  input  hburst_type                    hburst,
  input  logic                          hwait,
  output logic [MASTER_NUM-1:0]         hgrant,
  output logic                          hsel,
  output logic [$clog2(MASTER_NUM)-1:0] hmaster,
  output logic                          hlast
);

  localparam int MIDX_W = $clog2(MASTER_NUM);

  if (MASTER_NUM < 2 || MASTER_NUM > 16 || MAX_HOLD < 2 || MAX_HOLD > 255 ||
      (ARB_MODE != 0 && ARB_MODE != 1)) begin : g_param_check
    $error("ahb_slave_arbiter_gen: parameter out of range");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q;
  logic [MASTER_NUM-1:0]   grant_q;
  hburst_type              burst_q;
  logic                    first_q;   // first cycle of a transaction
  logic [4:0]              count_q;
  logic [MIDX_W-1:0]       rr_ptr_q;
  logic [MIDX_W-1:0]       hmaster_q;

  // burst_q is only written at the end of the first BUSY cycle, so during that
  // cycle the owner's live hburst stands in for it.
  hburst_type cur_burst;
  assign cur_burst = first_q ? hburst : burst_q;

  function automatic logic [4:0] beat_limit(input hburst_type b);
    case (b)
      WRAP4, INCR4:   beat_limit = 5'd3;
      WRAP8, INCR8:   beat_limit = 5'd7;
      WRAP16, INCR16: beat_limit = 5'd15;
      default:        beat_limit = 5'd0;
    endcase
  endfunction

  logic                  busy, is_incr, owner_req, timeout, last, done;
  logic [MASTER_NUM-1:0] others, cand;
  logic [MIDX_W-1:0]     owner_nxt, start;

  assign busy      = (state_q == BUSY);
  assign is_incr   = (cur_burst == INCR);
  assign owner_req = |(hreq & grant_q);
  assign others    = hreq & ~grant_q;
  // The owner competes again only when nobody else is asking.
  assign cand      = (|others) ? others : hreq;
  assign owner_nxt = (hmaster_q == MIDX_W'(MASTER_NUM - 1)) ? '0 : hmaster_q + 1'b1;
  // On a handover the pointer update and the search happen in the same cycle,
  // so the search starts from the value the pointer is about to take.
  assign start     = (ARB_MODE == 0) ? '0 : (busy ? owner_nxt : rr_ptr_q);

`ifdef ARB_INCR_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q;
  assign timeout = is_incr && (hold_q >= HOLD_LIM) && (|others);
`else
  assign timeout = 1'b0;
`endif

  assign last = busy && (is_incr ? (!owner_req || timeout)
                                 : (count_q == beat_limit(cur_burst)));
  assign done = last && !hwait;

  // Circular search over cand starting at 'start'.
  logic              win_vld;
  logic [MIDX_W-1:0] win_idx;
  always_comb begin
    // NOTE: every variable assigned here gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    int j;
    j       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      j = int'(start) + i;
      if (j >= MASTER_NUM) j = j - MASTER_NUM;
      if (!win_vld && cand[j[MIDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = j[MIDX_W-1:0];
      end
    end
  end

  logic [MASTER_NUM-1:0] win_onehot;
  assign win_onehot = {{(MASTER_NUM-1){1'b0}}, 1'b1} << win_idx;

  // NOTE: reset is asynchronous (in the sensitivity list); state updates use
  // non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      burst_q   <= SINGLE;
      first_q   <= 1'b0;
      count_q   <= '0;
      rr_ptr_q  <= '0;
      hmaster_q <= '0;
`ifdef ARB_INCR_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q   <= BUSY;
            grant_q   <= win_onehot;
            hmaster_q <= win_idx;
            first_q   <= 1'b1;
            count_q   <= '0;
`ifdef ARB_INCR_TIMEOUT_EN
            hold_q    <= '0;
`endif
          end else begin
            grant_q <= '0;
          end
        end
        BUSY: begin
          if (first_q) begin
            burst_q <= hburst;
            first_q <= 1'b0;
          end
          if (!hwait) count_q <= count_q + 5'd1;
`ifdef ARB_INCR_TIMEOUT_EN
          if (!hwait && is_incr && hold_q != 8'hFF) hold_q <= hold_q + 8'd1;
`endif
          if (done) begin
            rr_ptr_q <= owner_nxt;
            if (win_vld) begin
              grant_q   <= win_onehot;
              hmaster_q <= win_idx;
              first_q   <= 1'b1;
              count_q   <= '0;
`ifdef ARB_INCR_TIMEOUT_EN
              hold_q    <= '0;
`endif
            end else begin
              grant_q <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hgrant  = grant_q & {MASTER_NUM{~hwait}};
  assign hsel    = |grant_q;
  assign hmaster = hmaster_q;
  assign hlast   = last;

endmodule

// File: tb/tb_ahb_slave_arbiter_gen.sv
// -----------------------------------------------------------------------------
// tb_ahb_slave_arbiter_gen
//   Two arbiters share one stimulus stream: u_fix (fixed priority) and u_rr
//   (round robin, MAX_HOLD = 4). Each directed cycle pushes its hand-computed
//   expected outputs into a queue; the monitor pops one entry per cycle on the
//   falling edge and compares the selected instance(s).
// -----------------------------------------------------------------------------
module tb_ahb_slave_arbiter_gen;
  import AHB_package::*;

  logic       hclk = 1'b0;
  logic       hreset_n = 1'b0;
  logic [3:0] hreq = '0;
  hburst_type hburst = SINGLE;
  logic       hwait = 1'b0;

  logic [3:0] fix_grant, rr_grant;
  logic       fix_sel, rr_sel, fix_last, rr_last;
  logic [1:0] fix_master, rr_master;

  always #5 hclk = ~hclk;

  ahb_slave_arbiter_gen #(.MASTER_NUM(4), .ARB_MODE(0), .MAX_HOLD(16)) u_fix (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst), .hwait(hwait),
    .hgrant(fix_grant), .hsel(fix_sel), .hmaster(fix_master), .hlast(fix_last));

  ahb_slave_arbiter_gen #(.MASTER_NUM(4), .ARB_MODE(1), .MAX_HOLD(4)) u_rr (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst), .hwait(hwait),
    .hgrant(rr_grant), .hsel(rr_sel), .hmaster(rr_master), .hlast(rr_last));

  localparam int FIX = 0, RR = 1, BOTH = 2;

  typedef struct {
    int         sel;
    logic [3:0] g;
    logic       hs;
    logic [1:0] m;
    logic       l;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string nm, input string dut,
                       input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got grant=%b sel=%b master=%0d last=%b, want grant=%b sel=%b master=%0d last=%b",
               nm, dut, act[7:4], act[3], act[2:1], act[0], exp[7:4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  // Monitor: one expected entry per cycle, checked mid-cycle.
  always @(negedge hclk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.sel != RR)
        check(e.name, "fix", {fix_grant, fix_sel, fix_master, fix_last}, {e.g, e.hs, e.m, e.l});
      if (e.sel != FIX)
        check(e.name, "rr", {rr_grant, rr_sel, rr_master, rr_last}, {e.g, e.hs, e.m, e.l});
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue the
  // expected outputs for that same cycle.
  task automatic step(input int sel, input logic rn, input logic [3:0] rq,
                      input hburst_type b, input logic w,
                      input logic [3:0] g, input logic hs, input logic [1:0] m,
                      input logic l, input string nm);
    exp_t e;
    @(posedge hclk);
    #1;
    hreset_n = rn;
    hreq     = rq;
    hburst   = b;
    hwait    = w;
    e.sel = sel; e.g = g; e.hs = hs; e.m = m; e.l = l; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic rst();
    step(BOTH, 1'b0, 4'b0000, SINGLE, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, "reset");
  endtask

  initial begin
    // Initial reset: all outputs low.
    rst();

    // Lowest requester wins; owner re-wins when it is the only requester.
    step(BOTH, 1, 4'b0110, SINGLE, 0, 4'b0000, 0, 2'd0, 0, "a_idle");
    step(BOTH, 1, 4'b0110, SINGLE, 0, 4'b0010, 1, 2'd1, 1, "a_grant1");
    step(BOTH, 1, 4'b0100, SINGLE, 0, 4'b0100, 1, 2'd2, 1, "a_grant2");
    step(BOTH, 1, 4'b0000, SINGLE, 0, 4'b0100, 1, 2'd2, 1, "a_rewin2");
    step(BOTH, 1, 4'b0000, SINGLE, 0, 4'b0000, 0, 2'd2, 0, "a_idle_hold");

    // Fixed priority, all requesting: owner excluded -> 0,1,0,1.
    rst();
    step(FIX, 1, 4'b1111, SINGLE, 0, 4'b0000, 0, 2'd0, 0, "b_idle");
    step(FIX, 1, 4'b1111, SINGLE, 0, 4'b0001, 1, 2'd0, 1, "b_g0");
    step(FIX, 1, 4'b1111, SINGLE, 0, 4'b0010, 1, 2'd1, 1, "b_g1");
    step(FIX, 1, 4'b1111, SINGLE, 0, 4'b0001, 1, 2'd0, 1, "b_g0b");
    step(FIX, 1, 4'b0000, SINGLE, 0, 4'b0010, 1, 2'd1, 1, "b_g1b");
    step(FIX, 1, 4'b0000, SINGLE, 0, 4'b0000, 0, 2'd1, 0, "b_idle2");

    // Round robin, all requesting: 0,1,2,3,0; then pointer at 1 picks 3 over 0.
    rst();
    step(RR, 1, 4'b1111, SINGLE, 0, 4'b0000, 0, 2'd0, 0, "c_idle");
    step(RR, 1, 4'b1111, SINGLE, 0, 4'b0001, 1, 2'd0, 1, "c_g0");
    step(RR, 1, 4'b1111, SINGLE, 0, 4'b0010, 1, 2'd1, 1, "c_g1");
    step(RR, 1, 4'b1111, SINGLE, 0, 4'b0100, 1, 2'd2, 1, "c_g2");
    step(RR, 1, 4'b1111, SINGLE, 0, 4'b1000, 1, 2'd3, 1, "c_g3");
    step(RR, 1, 4'b0000, SINGLE, 0, 4'b0001, 1, 2'd0, 1, "c_g0b");
    step(RR, 1, 4'b1001, SINGLE, 0, 4'b0000, 0, 2'd0, 0, "c_idle2");
    step(RR, 1, 4'b0000, SINGLE, 0, 4'b1000, 1, 2'd3, 1, "c_ptr_g3");
    step(RR, 1, 4'b0000, SINGLE, 0, 4'b0000, 0, 2'd3, 0, "c_idle3");

    // INCR8 by master 2, waits on beats 3 and 8, master 0 requests mid-burst.
    rst();
    step(RR, 1, 4'b0100, INCR8,  0, 4'b0000, 0, 2'd0, 0, "d_idle");
    step(RR, 1, 4'b0100, INCR8,  0, 4'b0100, 1, 2'd2, 0, "d_b1");
    step(RR, 1, 4'b0100, INCR8,  0, 4'b0100, 1, 2'd2, 0, "d_b2");
    step(RR, 1, 4'b0101, INCR8,  1, 4'b0000, 1, 2'd2, 0, "d_b3_wait");
    step(RR, 1, 4'b0101, INCR8,  0, 4'b0100, 1, 2'd2, 0, "d_b3");
    step(RR, 1, 4'b0101, INCR8,  0, 4'b0100, 1, 2'd2, 0, "d_b4");
    step(RR, 1, 4'b0101, INCR8,  0, 4'b0100, 1, 2'd2, 0, "d_b5");
    step(RR, 1, 4'b0101, INCR8,  0, 4'b0100, 1, 2'd2, 0, "d_b6");
    step(RR, 1, 4'b0101, INCR8,  0, 4'b0100, 1, 2'd2, 0, "d_b7");
    step(RR, 1, 4'b0101, INCR8,  1, 4'b0000, 1, 2'd2, 1, "d_b8_wait");
    step(RR, 1, 4'b0101, SINGLE, 0, 4'b0100, 1, 2'd2, 1, "d_b8");
    step(RR, 1, 4'b0000, SINGLE, 0, 4'b0001, 1, 2'd0, 1, "d_next0");
    step(RR, 1, 4'b0000, SINGLE, 0, 4'b0000, 0, 2'd0, 0, "d_idle2");

    // INCR by master 0, request dropped on beat 5 (held by a wait), master 3 next.
    rst();
    step(FIX, 1, 4'b1001, INCR,   0, 4'b0000, 0, 2'd0, 0, "e_idle");
    step(FIX, 1, 4'b1001, INCR,   0, 4'b0001, 1, 2'd0, 0, "e_b1");
    step(FIX, 1, 4'b1001, INCR,   0, 4'b0001, 1, 2'd0, 0, "e_b2");
    step(FIX, 1, 4'b1001, INCR,   0, 4'b0001, 1, 2'd0, 0, "e_b3");
    step(FIX, 1, 4'b1001, INCR,   0, 4'b0001, 1, 2'd0, 0, "e_b4");
    step(FIX, 1, 4'b1000, INCR,   1, 4'b0000, 1, 2'd0, 1, "e_b5_wait");
    step(FIX, 1, 4'b1000, INCR,   0, 4'b0001, 1, 2'd0, 1, "e_b5");
    step(FIX, 1, 4'b0000, SINGLE, 0, 4'b1000, 1, 2'd3, 1, "e_g3");
    step(FIX, 1, 4'b0000, SINGLE, 0, 4'b0000, 0, 2'd3, 0, "e_idle2");

    // INCR by master 1 while master 2 waits (round robin instance, MAX_HOLD = 4).
    rst();
    step(RR, 1, 4'b0010, INCR, 0, 4'b0000, 0, 2'd0, 0, "f_idle");
    step(RR, 1, 4'b0110, INCR, 0, 4'b0010, 1, 2'd1, 0, "f_b1");
    step(RR, 1, 4'b0110, INCR, 0, 4'b0010, 1, 2'd1, 0, "f_b2");
    step(RR, 1, 4'b0110, INCR, 0, 4'b0010, 1, 2'd1, 0, "f_b3");
`ifdef ARB_INCR_TIMEOUT_EN
    step(RR, 1, 4'b0110, INCR,   0, 4'b0010, 1, 2'd1, 1, "f_b4_timeout");
    step(RR, 1, 4'b0000, SINGLE, 0, 4'b0100, 1, 2'd2, 1, "f_g2");
    step(RR, 1, 4'b0000, SINGLE, 0, 4'b0000, 0, 2'd2, 0, "f_idle2");
`else
    step(RR, 1, 4'b0110, INCR, 0, 4'b0010, 1, 2'd1, 0, "f_b4_no_timeout");
    step(RR, 1, 4'b0000, INCR, 0, 4'b0010, 1, 2'd1, 1, "f_b5_drop");
    step(RR, 1, 4'b0000, INCR, 0, 4'b0000, 0, 2'd1, 0, "f_idle2");
`endif

    // Reset during beat 2 of WRAP4, then a fresh grant to master 3.
    rst();
    step(BOTH, 1, 4'b0001, WRAP4,  0, 4'b0000, 0, 2'd0, 0, "g_idle");
    step(BOTH, 1, 4'b0001, WRAP4,  0, 4'b0001, 1, 2'd0, 0, "g_b1");
    step(BOTH, 0, 4'b0001, WRAP4,  0, 4'b0000, 0, 2'd0, 0, "g_reset_mid");
    step(BOTH, 1, 4'b1000, SINGLE, 0, 4'b0000, 0, 2'd0, 0, "g_release");
    step(BOTH, 1, 4'b0000, SINGLE, 0, 4'b1000, 1, 2'd3, 1, "g_g3");
    step(BOTH, 1, 4'b0000, SINGLE, 0, 4'b0000, 0, 2'd3, 0, "g_idle2");

    @(negedge hclk);
    #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
